// File: rtl/show_clk_gen.sv
// show_clk_gen: display scan clock, debounced manual/auto step clock and step counter
module show_clk_gen #(
  parameter int SCAN_DIV   = 50000,
  parameter int STEP_DIV   = 25000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_step,
  input  logic        run_mode,
  output logic        clk_r,
  output logic        clk_s,
  output logic [31:0] step_cnt,
  output logic        btn_level
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int TW = $clog2(STEP_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  deb_state_t state, state_d;
  logic [DW-1:0] deb_cnt, deb_cnt_d;
  logic [SW-1:0] scan_cnt;
  logic [TW-1:0] step_ctr;
  logic btn_s1, btn_s2, mode_s1, mode_s2;
  logic mode_prev, gate, clk_s_d;
  logic scan_hit, step_hit, deb_hit, mode_chg;
  assign scan_hit = scan_cnt == SW'(SCAN_DIV - 1);
  assign step_hit = step_ctr == TW'(STEP_DIV - 1);
  assign deb_hit  = deb_cnt == DW'(DEB_CYCLES - 1);
  assign mode_chg = mode_s2 != mode_prev;
  // two-flop synchronizers for the button and the mode switch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {btn_s2, btn_s1, mode_s2, mode_s1} <= '0;
    else {btn_s2, btn_s1, mode_s2, mode_s1} <= {btn_s1, btn_step, mode_s1, run_mode};
  // free-running scan divider, independent of mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan_cnt <= '0;
      clk_r    <= 1'b0;
    end else begin
      scan_cnt <= scan_hit ? '0 : scan_cnt + 1'b1;
      clk_r    <= scan_hit ? ~clk_r : clk_r;
    end
  // debounce next state: a level change must be stable for DEB_CYCLES samples
  always_comb begin
    state_d   = state;
    deb_cnt_d = deb_cnt;
    case (state)
      IDLE:
        if (btn_s2) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      PRESS_WAIT:
        if (!btn_s2) state_d = IDLE;
        else if (deb_hit) state_d = HELD;
        else deb_cnt_d = deb_cnt + 1'b1;
      HELD:
        if (!btn_s2) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      RELEASE_WAIT:
        if (btn_s2) state_d = HELD;
        else if (deb_hit) state_d = IDLE;
        else deb_cnt_d = deb_cnt + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // debounce state register; the LED level is registered from the current state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_d;
      deb_cnt   <= deb_cnt_d;
      btn_level <= state == HELD || state == RELEASE_WAIT;
    end
  // step clock: a mode change forces clk_s low and closes the gate; the gate reopens
  // after one low cycle (auto) or once the button level is seen released (manual)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_prev <= 1'b0;
      gate      <= 1'b0;
      clk_s     <= 1'b0;
      step_ctr  <= '0;
    end else if (mode_chg) begin
      mode_prev <= mode_s2;
      gate      <= 1'b0;
      clk_s     <= 1'b0;
      step_ctr  <= '0;
    end else if (!gate) begin
      gate  <= mode_prev | ~btn_level;
      clk_s <= 1'b0;
    end else if (mode_prev) begin
      step_ctr <= step_hit ? '0 : step_ctr + 1'b1;
      clk_s    <= step_hit ? ~clk_s : clk_s;
    end else begin
      clk_s <= btn_level;
    end
  // count clk_s rising edges, one cycle after each edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_s_d  <= 1'b0;
      step_cnt <= '0;
    end else begin
      clk_s_d  <= clk_s;
      step_cnt <= (clk_s & ~clk_s_d) ? step_cnt + 1'b1 : step_cnt;
    end
endmodule

// File: tb/tb_show_clk_gen.sv
// tb_show_clk_gen: directed checks of scan divider, debounce, step modes and reset
module tb_show_clk_gen;
  logic clk, rst_n, btn_step, run_mode;
  logic clk_r, clk_s, btn_level;
  logic [31:0] step_cnt;
  int n_checks, n_fail;
  int k, bl_rises, cs_rises, bl_first, cs_first;
  logic bl_prev, cs_prev, cs_rose;

  show_clk_gen #(.SCAN_DIV(4), .STEP_DIV(8), .DEB_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .run_mode(run_mode),
    .clk_r(clk_r), .clk_s(clk_s), .step_cnt(step_cnt), .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    k = 0;
    bl_rises = 0;
    cs_rises = 0;
    bl_first = -1;
    cs_first = -1;
    bl_prev = btn_level;
    cs_prev = clk_s;
    cs_rose = 1'b0;
  endtask

  // sample outputs on the falling edge, then drive the button for the next rising edge
  task automatic step(input logic b);
    @(negedge clk);
    k++;
    cs_rose = clk_s && !cs_prev;
    if (btn_level && !bl_prev) begin
      bl_rises++;
      if (bl_first < 0) bl_first = k;
    end
    if (cs_rose) begin
      cs_rises++;
      if (cs_first < 0) cs_first = k;
    end
    bl_prev = btn_level;
    cs_prev = clk_s;
    btn_step = b;
  endtask

  initial begin
    int toggles, bad;
    logic prev_r, found;
    logic [31:0] s0;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    btn_step = 1'b0;
    run_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_r", {31'b0, clk_r}, 0);
    check("rst_clk_s", {31'b0, clk_s}, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_btn_level", {31'b0, btn_level}, 0);
    rst_n = 1'b1;

    // idle manual mode: clk_r toggles every 4 cycles starting 4 edges after release
    clear_mon();
    toggles = 0;
    bad = 0;
    prev_r = clk_r;
    for (int i = 0; i < 64; i++) begin
      step(1'b0);
      if (clk_r != prev_r) begin
        toggles++;
        if (k % 4 != 0) bad++;
      end
      prev_r = clk_r;
    end
    check("scan_toggles", toggles, 16);
    check("scan_bad_phase", bad, 0);
    check("idle_cs_rises", cs_rises, 0);
    check("idle_step_cnt", step_cnt, 0);

    // bounce 1,0,1,0 then steady 1 driven from k=5 for 10 cycles
    clear_mon();
    s0 = step_cnt;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    repeat (10) step(1'b1);
    repeat (16) step(1'b0);
    check("man_bl_rises", bl_rises, 1);
    check("man_bl_first", bl_first, 12);
    check("man_cs_rises", cs_rises, 1);
    check("man_cs_first", cs_first, 13);
    check("man_step_delta", step_cnt - s0, 1);

    // switch to auto at k=1: first clk_s rise at k=13, then every 16; button ignored
    clear_mon();
    step(1'b0);
    run_mode = 1'b1;
    bad = 0;
    s0 = 0;
    for (int i = 0; i < 172; i++) begin
      step((k >= 39 && k < 80) ? 1'b1 : 1'b0);
      if (cs_rose && ((k - 13) % 16 != 0)) bad++;
      if (k == 13) s0 = step_cnt;
    end
    check("auto_cs_first", cs_first, 13);
    check("auto_bad_period", bad, 0);
    check("auto_step_delta", step_cnt - s0, 10);
    check("auto_btn_debounced", bl_rises, 1);

    // auto->manual while clk_s high and button held
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1'b1);
      found = cs_rose && btn_level;
    end
    check("sw_found_high", {31'b0, found}, 1);
    run_mode = 1'b0;
    step(1'b1);
    step(1'b1);
    check("sw_pre_detect", {31'b0, clk_s}, 1);
    step(1'b1);
    check("sw_drop", {31'b0, clk_s}, 0);
    s0 = step_cnt;
    clear_mon();
    repeat (20) step(1'b1);
    check("sw_held_no_edge", cs_rises, 0);
    repeat (10) step(1'b0);
    repeat (10) step(1'b1);
    repeat (12) step(1'b0);
    check("sw_single_edge", cs_rises, 1);
    check("sw_step_delta", step_cnt - s0, 1);

    // reset during PRESS_WAIT with the button held
    repeat (4) step(1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_clk_r", {31'b0, clk_r}, 0);
    check("arst_clk_s", {31'b0, clk_s}, 0);
    check("arst_step_cnt", step_cnt, 0);
    check("arst_btn_level", {31'b0, btn_level}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (12) step(1'b1);
    check("arst_requal_first", bl_first, 7);

    // step_cnt wrap from all-ones on one manual press
    repeat (15) step(1'b0);
    force dut.step_cnt = 32'hFFFF_FFFF;
    step(1'b0);
    release dut.step_cnt;
    repeat (3) step(1'b0);
    repeat (10) step(1'b1);
    repeat (12) step(1'b0);
    check("wrap_step_cnt", step_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
